// File: rtl/samp_rate_ctrl.sv
// samp_rate_ctrl: selectable-ratio sample strobe generator with power-up delay and glitch-free mode switching
// Ports: Fg_CLK/RESET clock and sync reset; BtnUp/BtnDn edge-triggered mode step requests;
// ModeLd/ModeIn direct mode load; Ready power-up done; Enable sample strobe; Mode active mode;
// ModeChg one-cycle switch pulse; Pending a requested mode awaits the next period boundary.
module samp_rate_ctrl #(
  parameter int NUM_MODES = 5,
  parameter int MODE_W    = 3,
  parameter int CNT_W     = 16,
  parameter int DIV_BASE  = 10,
  parameter int READY_DLY = 80
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              BtnUp,
  input  logic              BtnDn,
  input  logic              ModeLd,
  input  logic [MODE_W-1:0] ModeIn,
  output logic              Ready,
  output logic              Enable,
  output logic [MODE_W-1:0] Mode,
  output logic              ModeChg,
  output logic              Pending
);
  localparam int RW = $clog2(READY_DLY + 1);
  function automatic longint pw(input int e);
    longint r = 1;
    for (int k = 0; k < e; k++) r = r * DIV_BASE;
    return r;
  endfunction
  localparam longint TMAX = pw(NUM_MODES - 1) - 1;
  if (TMAX >= (longint'(1) << CNT_W)) begin : g_chk
    $error("samp_rate_ctrl: largest terminal count does not fit in CNT_W bits");
  end
  // Table padded to the full Mode range so any Mode value indexes safely.
  logic [CNT_W-1:0] tab [2**MODE_W];
  for (genvar i = 0; i < 2**MODE_W; i++) begin : g_tab
    assign tab[i] = (i < NUM_MODES) ? CNT_W'(pw(i) - 1) : '0;
  end
  logic [RW-1:0]     rdy_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [MODE_W-1:0] tgt, m_up, m_dn, req_m;
  logic              up_q, dn_q, up_e, dn_e, ld_ok, req, wrap;
  always_comb begin
    up_e  = BtnUp & ~up_q;
    dn_e  = BtnDn & ~dn_q;
    m_up  = (Mode == MODE_W'(NUM_MODES - 1)) ? '0 : Mode + MODE_W'(1);
    m_dn  = (Mode == '0) ? MODE_W'(NUM_MODES - 1) : Mode - MODE_W'(1);
    ld_ok = ModeLd & ({1'b0, ModeIn} < (MODE_W + 1)'(NUM_MODES));
    // A load strobe masks button edges even when its value is out of range.
    req   = Ready & (ModeLd ? ld_ok : (up_e ^ dn_e));
    req_m = ModeLd ? ModeIn : (up_e ? m_up : m_dn);
    wrap  = Ready & (cnt == tab[Mode]);
  end
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      rdy_cnt <= '0;
      Ready   <= 1'b0;
      Enable  <= 1'b0;
      Mode    <= '0;
      ModeChg <= 1'b0;
      Pending <= 1'b0;
      tgt     <= '0;
      cnt     <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      up_q    <= BtnUp;
      dn_q    <= BtnDn;
      if (!Ready) rdy_cnt <= rdy_cnt + RW'(1);
      Ready   <= Ready | (rdy_cnt == RW'(READY_DLY - 1));
      Enable  <= wrap;
      ModeChg <= wrap & Pending;
      cnt     <= wrap ? '0 : (Ready ? cnt + CNT_W'(1) : '0);
      if (wrap & Pending) begin
        Mode    <= tgt;
        Pending <= 1'b0;
      end
      // A request on the boundary edge is latched after the apply, so it waits a full period.
      if (req) begin
        tgt     <= req_m;
        Pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_samp_rate_ctrl.sv
// tb_samp_rate_ctrl: directed self-checking bench for samp_rate_ctrl with default parameters
module tb_samp_rate_ctrl;
  logic       clk = 0, rst = 1, up = 0, dn = 0, ld = 0;
  logic [2:0] mode_in = 0, mode;
  logic       ready, enable, mode_chg, pending;
  int         errors = 0, checks = 0;
  samp_rate_ctrl dut (
    .Fg_CLK(clk), .RESET(rst), .BtnUp(up), .BtnDn(dn), .ModeLd(ld), .ModeIn(mode_in),
    .Ready(ready), .Enable(enable), .Mode(mode), .ModeChg(mode_chg), .Pending(pending)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_chg(input int bound);
    int n = 0;
    while (!mode_chg && n < bound) begin
      step(1);
      n++;
    end
    chk("wait_modechg", {31'b0, mode_chg}, 1);
  endtask
  initial begin
    int cnt;
    step(2);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_enable", {31'b0, enable}, 0);
    chk("rst_mode", {29'b0, mode}, 0);
    chk("rst_pending", {31'b0, pending}, 0);
    chk("rst_modechg", {31'b0, mode_chg}, 0);
    rst = 0;
    step(79);
    chk("ready_79", {31'b0, ready}, 0);
    chk("enable_79", {31'b0, enable}, 0);
    step(1);
    chk("ready_80", {31'b0, ready}, 1);
    step(1);
    chk("enable_m0_a", {31'b0, enable}, 1);
    step(1);
    chk("enable_m0_b", {31'b0, enable}, 1);
    up = 1;
    step(1);
    up = 0;
    chk("up_pending", {31'b0, pending}, 1);
    chk("up_mode_before", {29'b0, mode}, 0);
    step(1);
    chk("up_modechg", {31'b0, mode_chg}, 1);
    chk("up_mode", {29'b0, mode}, 1);
    chk("up_pending_clr", {31'b0, pending}, 0);
    step(9);
    chk("m1_enable_9", {31'b0, enable}, 0);
    step(1);
    chk("m1_enable_10", {31'b0, enable}, 1);
    chk("m1_modechg_gone", {31'b0, mode_chg}, 0);
    step(1);
    chk("m1_enable_11", {31'b0, enable}, 0);
    step(9);
    chk("m1_enable_20", {31'b0, enable}, 1);
    up = 1;
    dn = 1;
    step(1);
    up = 0;
    dn = 0;
    chk("both_pending", {31'b0, pending}, 0);
    step(15);
    chk("both_mode", {29'b0, mode}, 1);
    up = 1;
    cnt = 0;
    repeat (50) begin
      step(1);
      if (mode_chg) cnt++;
    end
    up = 0;
    chk("hold_one_chg", cnt, 1);
    chk("hold_mode", {29'b0, mode}, 2);
    ld = 1;
    mode_in = 3;
    step(1);
    chk("ld3_pending", {31'b0, pending}, 1);
    mode_in = 6;
    step(1);
    ld = 0;
    chk("ld6_keeps_pending", {31'b0, pending}, 1);
    chk("ld6_mode", {29'b0, mode}, 2);
    rst = 1;
    step(1);
    rst = 0;
    chk("mid_rst_mode", {29'b0, mode}, 0);
    chk("mid_rst_pending", {31'b0, pending}, 0);
    chk("mid_rst_ready", {31'b0, ready}, 0);
    step(79);
    chk("rerdy_79", {31'b0, ready}, 0);
    step(1);
    chk("rerdy_80", {31'b0, ready}, 1);
    dn = 1;
    step(1);
    dn = 0;
    chk("dn_pending", {31'b0, pending}, 1);
    step(1);
    chk("dn_modechg", {31'b0, mode_chg}, 1);
    chk("dn_mode", {29'b0, mode}, 4);
    cnt = 0;
    repeat (9999) begin
      step(1);
      if (enable) cnt++;
    end
    chk("m4_no_enable", cnt, 0);
    step(1);
    chk("m4_enable", {31'b0, enable}, 1);
    ld = 1;
    mode_in = 3;
    step(1);
    ld = 0;
    wait_chg(10001);
    chk("m3_mode", {29'b0, mode}, 3);
    step(500);
    ld = 1;
    mode_in = 1;
    step(1);
    ld = 0;
    cnt = 0;
    repeat (499) begin
      if (pending && mode == 3) cnt++;
      step(1);
    end
    chk("m3_pending_cycles", cnt, 499);
    chk("m3_to_m1_chg", {31'b0, mode_chg}, 1);
    chk("m3_to_m1_mode", {29'b0, mode}, 1);
    chk("m3_to_m1_pending", {31'b0, pending}, 0);
    ld = 1;
    mode_in = 6;
    step(1);
    ld = 0;
    chk("ld6_ignored", {31'b0, pending}, 0);
    step(20);
    chk("ld6_mode_kept", {29'b0, mode}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
